// File: rtl/des_crypt_pipe_pkg.sv
// Shared DES constants, permutation tables and the round primitives.
package des_crypt_pipe_pkg;

  localparam int N_B  = 64;
  localparam int N_K  = 64;
  localparam int N_R  = 16;
  localparam int N_CD = 56;
  localparam int N_RK = 48;

  // Per-round left-rotation amounts of each 28-bit key half.
  localparam int SHIFT [N_R] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Tables use DES numbering: entry value n selects input bit n, bit 1 being the MSB.
  localparam byte unsigned IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam byte unsigned FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam byte unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam byte unsigned PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam byte unsigned E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam byte unsigned P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // S-boxes S1..S8, row-major, 4 bits per entry, entry 0 in the top nibble.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    for (int i = 0; i < 64; i++) perm_ip[63-i] = x[64-int'(IP_T[i])];
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    for (int i = 0; i < 64; i++) perm_fp[63-i] = x[64-int'(FP_T[i])];
  endfunction

  function automatic logic [N_CD-1:0] perm_pc1(input logic [N_K-1:0] x);
    for (int i = 0; i < N_CD; i++) perm_pc1[N_CD-1-i] = x[64-int'(PC1_T[i])];
  endfunction

  function automatic logic [N_RK-1:0] perm_pc2(input logic [N_CD-1:0] x);
    for (int i = 0; i < N_RK; i++) perm_pc2[N_RK-1-i] = x[56-int'(PC2_T[i])];
  endfunction

  // Rotate both 28-bit key halves left / right by 1 or 2.
  function automatic logic [N_CD-1:0] cd_rotl(input logic [N_CD-1:0] cd, input int n);
    return (n == 1) ? {cd[54:28], cd[55], cd[26:0], cd[27]}
                    : {cd[53:28], cd[55:54], cd[25:0], cd[27:26]};
  endfunction

  function automatic logic [N_CD-1:0] cd_rotr(input logic [N_CD-1:0] cd, input int n);
    return (n == 1) ? {cd[28], cd[55:29], cd[0], cd[27:1]}
                    : {cd[29:28], cd[55:30], cd[1:0], cd[27:2]};
  endfunction

  // Cipher function f(R, K): expand, key mix, S-box substitution, P permutation.
  function automatic logic [31:0] des_f(input logic [31:0] r, input logic [N_RK-1:0] k);
    logic [47:0] e;
    logic [31:0] s;
    logic [5:0]  b;
    int          idx;
    for (int i = 0; i < 48; i++) e[47-i] = r[32-int'(E_T[i])];
    e = e ^ k;
    for (int i = 0; i < 8; i++) begin
      b   = e[47-6*i -: 6];
      idx = int'({b[5], b[0], b[4:1]});
      s[31-4*i -: 4] = SBOX[i][255-4*idx -: 4];
    end
    for (int i = 0; i < 32; i++) des_f[31-i] = s[32-int'(P_T[i])];
  endfunction

  // One Feistel round on {L, R}: L' = R, R' = L ^ f(R, K).
  function automatic logic [63:0] des_round(input logic [63:0] lr, input logic [N_RK-1:0] k);
    return {lr[31:0], lr[63:32] ^ des_f(lr[31:0], k)};
  endfunction

endpackage

// File: rtl/des_stage.sv
// Combinational group of RPS DES rounds starting at round index FIRST.
module des_stage
  import des_crypt_pipe_pkg::*;
#(
  parameter int RPS   = 1,
  parameter int FIRST = 0
) (
  input  logic [31:0]     l_i,
  input  logic [31:0]     r_i,
  input  logic [N_CD-1:0] cd_i,
  input  logic            decrypt_i,
  output logic [31:0]     l_o,
  output logic [31:0]     r_o,
  output logic [N_CD-1:0] cd_o
);

  logic [63:0]     lr_c;
  logic [N_CD-1:0] cd_c;

  // Chain the rounds; encrypt rotates before PC2, decrypt rotates back after it.
  always_comb begin
    // NOTE: blocking assignments let each round see the previous round's result in the same evaluation.
    lr_c = {l_i, r_i};
    cd_c = cd_i;
    for (int rnd = 0; rnd < RPS; rnd++) begin
      if (!decrypt_i) begin
        cd_c = cd_rotl(cd_c, SHIFT[FIRST+rnd]);
        lr_c = des_round(lr_c, perm_pc2(cd_c));
      end else begin
        lr_c = des_round(lr_c, perm_pc2(cd_c));
        cd_c = cd_rotr(cd_c, SHIFT[N_R-1-FIRST-rnd]);
      end
    end
    l_o  = lr_c[63:32];
    r_o  = lr_c[31:0];
    cd_o = cd_c;
  end

endmodule

// File: rtl/des_crypt_pipe.sv
// Fully pipelined DES encrypt/decrypt engine, one block per cycle, global-stall handshake.
module des_crypt_pipe
  import des_crypt_pipe_pkg::*;
#(
  parameter int RPS   = 1,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_K-1:0]   in_key,
  input  logic [N_B-1:0]   in_data,
  input  logic             in_decrypt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_B-1:0]   out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int S = N_R / RPS;

  typedef struct packed {
    logic             valid;
    logic             decrypt;
    logic [TAG_W-1:0] tag;
    logic [31:0]      l;
    logic [31:0]      r;
    logic [N_CD-1:0]  cd;
  } stage_t;

  stage_t          stage_q [S];
  stage_t          stage_d [S];
  logic [31:0]     l_o  [S];
  logic [31:0]     r_o  [S];
  logic [N_CD-1:0] cd_o [S];
  logic [N_B-1:0]  ip_w;
  logic [N_CD-1:0] cd0_w;
  logic            adv;

  assign ip_w  = perm_ip(in_data);
  assign cd0_w = perm_pc1(in_key);
  assign adv   = !out_valid || out_ready;

  for (genvar k = 0; k < S; k++) begin : g_stage
    if (k == 0) begin : g_first
      des_stage #(.RPS(RPS), .FIRST(0)) u_stage (
        .l_i(ip_w[63:32]), .r_i(ip_w[31:0]), .cd_i(cd0_w), .decrypt_i(in_decrypt),
        .l_o(l_o[k]), .r_o(r_o[k]), .cd_o(cd_o[k])
      );
    end else begin : g_next
      des_stage #(.RPS(RPS), .FIRST(k*RPS)) u_stage (
        .l_i(stage_q[k-1].l), .r_i(stage_q[k-1].r), .cd_i(stage_q[k-1].cd),
        .decrypt_i(stage_q[k-1].decrypt),
        .l_o(l_o[k]), .r_o(r_o[k]), .cd_o(cd_o[k])
      );
    end
  end

  // Next stage state: whole pipe shifts on adv, otherwise everything holds.
  always_comb begin
    // NOTE: every stage gets a default first so no path leaves a stage unassigned.
    for (int k = 0; k < S; k++) stage_d[k] = stage_q[k];
    if (adv) begin
      stage_d[0] = '{valid: in_valid, decrypt: in_decrypt, tag: in_tag,
                     l: l_o[0], r: r_o[0], cd: cd_o[0]};
      for (int k = 1; k < S; k++) begin
        stage_d[k] = '{valid: stage_q[k-1].valid, decrypt: stage_q[k-1].decrypt,
                       tag: stage_q[k-1].tag, l: l_o[k], r: r_o[k], cd: cd_o[k]};
      end
    end
  end

  // Stage registers with asynchronous clear of control and data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: data fields are cleared too so the idle output reads FP(0) = 0.
      for (int k = 0; k < S; k++) stage_q[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every stage sampling its predecessor's old value.
      for (int k = 0; k < S; k++) stage_q[k] <= stage_d[k];
    end
  end

  // Output from the last stage: swap halves, final permutation; busy is any valid bit.
  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < S; k++) busy = busy | stage_q[k].valid;
  end

  assign out_valid = stage_q[S-1].valid;
  assign out_data  = perm_fp({stage_q[S-1].r, stage_q[S-1].l});
  assign out_tag   = stage_q[S-1].tag;
  assign in_ready  = adv;

endmodule

// File: tb/tb_des_crypt_pipe.sv
// Directed bench for des_crypt_pipe at RPS = 1, 4 and 16 sharing one stimulus stream.
module tb_des_crypt_pipe;

  localparam int ND = 3;
  localparam int LAT [ND] = '{16, 4, 1};

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] P2 = 64'h8787878787878787;
  localparam logic [63:0] C2 = 64'h0000000000000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_decrypt, out_ready;
  logic [63:0] in_key, in_data;
  logic [3:0]  in_tag;
  logic        ir [ND];
  logic        ov [ND];
  logic        bz [ND];
  logic [63:0] od [ND];
  logic [3:0]  ot [ND];

  int n_vec = 0;
  int n_mis = 0;

  typedef struct { logic [63:0] data; logic [3:0] tag; } exp_t;
  exp_t exp_q [$];

  always #5 clk = ~clk;

  des_crypt_pipe #(.RPS(1), .TAG_W(4)) u_rps1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_key(in_key),
    .in_data(in_data), .in_decrypt(in_decrypt), .in_tag(in_tag), .out_valid(ov[0]),
    .out_ready(out_ready), .out_data(od[0]), .out_tag(ot[0]), .busy(bz[0]));
  des_crypt_pipe #(.RPS(4), .TAG_W(4)) u_rps4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_key(in_key),
    .in_data(in_data), .in_decrypt(in_decrypt), .in_tag(in_tag), .out_valid(ov[1]),
    .out_ready(out_ready), .out_data(od[1]), .out_tag(ot[1]), .busy(bz[1]));
  des_crypt_pipe #(.RPS(16), .TAG_W(4)) u_rps16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_key(in_key),
    .in_data(in_data), .in_decrypt(in_decrypt), .in_tag(in_tag), .out_valid(ov[2]),
    .out_ready(out_ready), .out_data(od[2]), .out_tag(ot[2]), .busy(bz[2]));

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One isolated block; check each DUT goes valid exactly at its latency.
  task automatic single(input string nm, input logic [63:0] key, input logic [63:0] data,
                        input logic dec, input logic [3:0] tag, input logic [63:0] exp);
    @(negedge clk);
    in_valid = 1'b1; in_key = key; in_data = data; in_decrypt = dec; in_tag = tag;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (n == 0) in_valid = 1'b0;
      for (int d = 0; d < ND; d++) begin
        if (n == LAT[d] - 2) chk($sformatf("%s_early_valid[%0d]", nm, d), ov[d], 1'b0);
        if (n == LAT[d] - 1) begin
          chk($sformatf("%s_valid[%0d]", nm, d), ov[d], 1'b1);
          chk($sformatf("%s_data[%0d]", nm, d), od[d], exp);
          chk($sformatf("%s_tag[%0d]", nm, d), ot[d], tag);
        end
      end
    end
  endtask

  initial begin
    logic        hold_prev;
    logic [63:0] prev_od;
    logic [3:0]  prev_ot;
    logic [3:0]  tagc;
    int          v;
    exp_t        e;

    rst = 1'b1; in_valid = 1'b0; in_key = '0; in_data = '0; in_decrypt = 1'b0;
    in_tag = '0; out_ready = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst_out_valid[%0d]", d), ov[d], 1'b0);
      chk($sformatf("rst_busy[%0d]", d), bz[d], 1'b0);
      chk($sformatf("rst_in_ready[%0d]", d), ir[d], 1'b1);
      chk($sformatf("rst_out_data[%0d]", d), od[d], 64'h0);
      chk($sformatf("rst_out_tag[%0d]", d), ot[d], 4'h0);
    end
    apply_reset();

    // Known-answer encrypt and decrypt.
    single("enc", K1, P1, 1'b0, 4'd3, C1);
    single("dec", K1, C1, 1'b1, 4'd9, P1);

    // Mixed stream: 32 back-to-back blocks alternating encrypt/decrypt.
    apply_reset();
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (n >= 1) begin
        for (int d = 0; d < ND; d++) begin
          int idx;
          idx = (n - 1) - (LAT[d] - 1);
          chk($sformatf("mix_in_ready[%0d]", d), ir[d], 1'b1);
          if (idx < 0) chk($sformatf("mix_idle[%0d]", d), ov[d], 1'b0);
          else if (idx < 32) begin
            chk($sformatf("mix_valid[%0d]", d), ov[d], 1'b1);
            chk($sformatf("mix_data[%0d]", d), od[d], idx[0] ? P2 : C2);
            chk($sformatf("mix_tag[%0d]", d), ot[d], idx[3:0]);
          end
        end
      end
      in_valid = (n < 32);
      in_key = K2;
      in_decrypt = n[0];
      in_data = n[0] ? C2 : P2;
      in_tag = n[3:0];
    end

    // Random back-pressure against a scoreboard (RPS = 1 instance).
    apply_reset();
    hold_prev = 1'b0; prev_od = '0; prev_ot = '0; tagc = '0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) != 0);
      v = $urandom_range(0, 3);
      in_key = (v < 2) ? K1 : K2;
      in_decrypt = v[0];
      case (v)
        0: begin in_data = P1; e.data = C1; end
        1: begin in_data = C1; e.data = P1; end
        2: begin in_data = P2; e.data = C2; end
        default: begin in_data = C2; e.data = P2; end
      endcase
      in_tag = tagc;
      e.tag = tagc;
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      chk("bp_in_ready", ir[0], !ov[0] || out_ready);
      if (hold_prev) begin
        chk("bp_hold_valid", ov[0], 1'b1);
        chk("bp_hold_data", od[0], prev_od);
        chk("bp_hold_tag", ot[0], prev_ot);
      end
      if (ov[0] && out_ready) begin
        chk("bp_have_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          chk("bp_data", od[0], exp_q[0].data);
          chk("bp_tag", ot[0], exp_q[0].tag);
          void'(exp_q.pop_front());
        end
      end
      if (in_valid && ir[0]) begin
        exp_q.push_back(e);
        tagc = tagc + 4'd1;
      end
      hold_prev = ov[0] && !out_ready;
      prev_od = od[0];
      prev_ot = ot[0];
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (ov[0]) begin
        chk("drain_have_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          chk("drain_data", od[0], exp_q[0].data);
          chk("drain_tag", ot[0], exp_q[0].tag);
          void'(exp_q.pop_front());
        end
      end
      @(negedge clk);
    end
    chk("drain_left", exp_q.size(), 0);
    chk("drain_idle", ov[0], 1'b0);

    // Reset with the RPS = 1 pipe half full.
    apply_reset();
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      in_valid = 1'b1; in_key = K1; in_data = P1; in_decrypt = 1'b0; in_tag = n[3:0];
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_busy", bz[0], 1'b1);
    #1;
    rst = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("mid_rst_out_valid[%0d]", d), ov[d], 1'b0);
      chk($sformatf("mid_rst_busy[%0d]", d), bz[d], 1'b0);
      chk($sformatf("mid_rst_out_data[%0d]", d), od[d], 64'h0);
      chk($sformatf("mid_rst_in_ready[%0d]", d), ir[d], 1'b1);
    end
    @(negedge clk);
    rst = 1'b0;
    single("post_rst", K1, P1, 1'b0, 4'd5, C1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
